// File: rtl/regfile_write_queue.sv
// -----------------------------------------------------------------------------
// regfile_write_queue
//
// Purpose
//   In-order buffer for register-file write requests coming from producers
//   that can finish in the same cycle (ALU writeback, multdiv, memory). The
//   queue drains at most one entry per cycle into a registered write port,
//   so the register file sees a single write strobe per cycle.
//
// Ports
//   clk       rising-edge clock
//   clr       synchronous, active-high reset (priority over push and pop)
//   wq_valid  producer request valid
//   wq_ready  queue can accept (equals !full)
//   wq_addr   destination register index (index 0 is accepted and dropped)
//   wq_data   write data
//   rf_stall  hold the queue head this cycle, no drain
//   rf_we     registered one-cycle write strobe to the register file
//   rf_addr   registered write index (held while rf_we is low)
//   rf_data   registered write data  (held while rf_we is low)
//   full      count == DEPTH
//   empty     count == 0
//   count     entries queued, the output register excluded
//   fwd_addr  forwarding lookup index
//   fwd_hit   a pending write to fwd_addr exists
//   fwd_data  data of the newest pending write to fwd_addr
//
// Configuration
//   REGWQ_FORWARD_EN  when defined, fwd_hit/fwd_data search the queued entries
//                     (newest first) and then the output register while rf_we
//                     is high. When undefined the forwarding ports are tied to
//                     zero and no compare logic exists.
// -----------------------------------------------------------------------------
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       wq_valid,
    output logic                       wq_ready,
    input  logic [ADDR_W-1:0]          wq_addr,
    input  logic [DATA_W-1:0]          wq_data,
    input  logic                       rf_stall,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_addr,
    output logic [DATA_W-1:0]          rf_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Storage holds data only; it is never reset because validity is
    // defined entirely by rd_ptr/count.
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;

    logic push_acc;
    logic push_en;
    logic pop_en;

    // full/empty come from the occupancy counter: with natural pointer wrap,
    // rd_ptr == wr_ptr is ambiguous between the two.
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign wq_ready = !full;

    // A request to r0 completes the handshake but stores nothing.
    assign push_acc = wq_valid && wq_ready;
    assign push_en  = push_acc && (wq_addr != '0);

    // Pop decision uses the current occupancy, so an entry pushed into an
    // empty queue is only drained on the following edge (no bypass).
    assign pop_en   = !empty && !rf_stall;

    // ---- queue write stage ----
    always_ff @(posedge clk) begin
        if (push_en && !clr) begin
            mem_addr[wr_ptr] <= wq_addr;
            mem_data[wr_ptr] <= wq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---- output register stage ----
    // rf_addr/rf_data hold their last value while rf_we is low.
    always_ff @(posedge clk) begin
        if (clr) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (pop_en) begin
            rf_we   <= 1'b1;
            rf_addr <= mem_addr[rd_ptr];
            rf_data <= mem_data[rd_ptr];
        end else begin
            rf_we   <= 1'b0;
        end
    end

`ifdef REGWQ_FORWARD_EN
    // Priority, lowest first: output register, then queue entries from
    // oldest to newest, so the last match found is the newest write.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (rf_we && (rf_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < cnt_q) && (mem_addr[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[idx];
            end
        end
        // r0 never has a pending value.
        if (fwd_addr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_queue
//
// Bench for regfile_write_queue. A behavioural model (a plain SystemVerilog
// queue of pending writes plus the expected write-port register) is stepped
// once per clock and every visible output is compared with it. Directed
// sequences cover reset, latency, full/back-pressure, r0 drop, wrap-around
// and forwarding; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_regfile_write_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH+1);

`ifdef REGWQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic              wq_valid;
    logic              wq_ready;
    logic [ADDR_W-1:0] wq_addr;
    logic [DATA_W-1:0] wq_data;
    logic              rf_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    regfile_write_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .wq_valid (wq_valid),
        .wq_ready (wq_ready),
        .wq_addr  (wq_addr),
        .wq_data  (wq_data),
        .rf_stall (rf_stall),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model state
    ent_t              mq[$];
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies one cycle of inputs, compares the current outputs with the
    // model, advances the model across the next rising edge and returns at
    // the following falling edge.
    task automatic cycle(input bit c, input bit v, input bit s,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] fa);
        bit                e_hit;
        logic [DATA_W-1:0] e_fd;
        bit                do_pop;
        bit                do_push;
        clr      = c;
        wq_valid = v;
        rf_stall = s;
        wq_addr  = a;
        wq_data  = d;
        fwd_addr = fa;
        #1;
        chk("count",    count,    mq.size());
        chk("full",     full,     mq.size() == DEPTH);
        chk("empty",    empty,    mq.size() == 0);
        chk("wq_ready", wq_ready, mq.size() != DEPTH);
        chk("rf_we",    rf_we,    m_we);
        chk("rf_addr",  rf_addr,  m_addr);
        chk("rf_data",  rf_data,  m_data);

        // Newest pending write to fa: search queue back-to-front, then the
        // write port while its strobe is high.
        e_hit = 1'b0;
        e_fd  = '0;
        if (FWD && fa != 0) begin
            for (int i = mq.size() - 1; i >= 0 && !e_hit; i--) begin
                if (mq[i].a == fa) begin
                    e_hit = 1'b1;
                    e_fd  = mq[i].d;
                end
            end
            if (!e_hit && m_we && m_addr == fa) begin
                e_hit = 1'b1;
                e_fd  = m_data;
            end
        end
        chk("fwd_hit",  fwd_hit,  e_hit);
        chk("fwd_data", fwd_data, e_fd);

        if (c) begin
            mq.delete();
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            do_pop  = (mq.size() > 0) && !s;
            do_push = v && (mq.size() < DEPTH);
            if (do_pop) begin
                m_we   = 1'b1;
                m_addr = mq[0].a;
                m_data = mq[0].d;
                void'(mq.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (do_push && a != 0) begin
                mq.push_back('{a: a, d: d});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        clr      = 1'b1;
        wq_valid = 1'b0;
        rf_stall = 1'b0;
        wq_addr  = '0;
        wq_data  = '0;
        fwd_addr = '0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_we",    rf_we, 0);

        // Single write latency
        cycle(0, 1, 0, 5, 32'hDEADBEEF, 0);
        chk("lat_we_n1", rf_we, 1'b0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("lat_we",   rf_we,   1'b1);
        chk("lat_addr", rf_addr, 5);
        chk("lat_data", rf_data, 32'hDEADBEEF);
        cycle(0, 0, 0, 0, 0, 0);
        chk("lat_we_off", rf_we, 1'b0);

        // Fill under stall, hold a 5th request, then release
        for (int i = 1; i <= 4; i++) cycle(0, 1, 1, 5'(i), 32'hA000 + i, 0);
        chk("full_flag",  full,     1'b1);
        chk("full_ready", wq_ready, 1'b0);
        cycle(0, 1, 1, 9, 32'hA005, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 9, 32'hA005, 0);
        idle(6);

        // clr with 3 entries queued
        for (int i = 1; i <= 3; i++) cycle(0, 1, 1, 5'(10 + i), 32'hB000 + i, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1'b1);
        idle(4);

        // r0 write is swallowed
        cycle(0, 1, 1, 3, 32'h55, 0);
        cycle(0, 1, 1, 0, 32'h1234, 0);
        chk("r0_count", count, 1);
        idle(3);

        // Continuous push/pop with two entries in flight
        cycle(0, 1, 1, 1, 32'hC000, 0);
        cycle(0, 1, 1, 2, 32'hC001, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 5'(3 + i), 32'hC002 + i, 0);
        chk("stream_count", count, 2);
        idle(4);

        // Forwarding, newest write wins
        cycle(0, 1, 1, 7, 32'h11, 0);
        cycle(0, 1, 1, 7, 32'h22, 0);
        cycle(0, 0, 1, 0, 0, 7);
        fwd_addr = 7;
        #1;
        chk("fwd7_hit",  fwd_hit,  FWD);
        chk("fwd7_data", fwd_data, FWD ? 32'h22 : 32'h0);
        fwd_addr = 0;
        #1;
        chk("fwd0_hit", fwd_hit, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 7);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(63) == 0),
                  ($urandom_range(2) != 0),
                  ($urandom_range(2) == 0),
                  5'($urandom_range(7)),
                  $urandom,
                  5'($urandom_range(7)));
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
